// File: rtl/mc_4ph_sender_if.sv
// Handshake bundle for mc_4ph_sender: clocked producer side (valid/ready) and the
// bundled-data 4-phase side facing the Muller C-element pipeline.
interface mc_4ph_sender_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i;

    modport master (
        input  in_valid, in_data, ack_i,
        output in_ready, req_o, data_o
    );

    modport slave (
        output in_valid, in_data, ack_i,
        input  in_ready, req_o, data_o
    );
endinterface

// File: rtl/mc_4ph_sender.sv
// Clocked-to-asynchronous 4-phase bundled-data sender with synchronized acknowledge.
// Optional ack timeout with sticky error flag when MC_4PH_TIMEOUT_EN is defined.
module mc_4ph_sender #(
    parameter int DATA_W         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mc_4ph_sender_if.master        bus,
    output logic [7:0]             xfer_cnt,
    output logic                   err_o,
    input  logic                   clr_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    // ack_i is asynchronous to clk; only the last flop of the chain is trusted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_i};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

`ifdef MC_4PH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       wait_hit;

    assign wait_hit = (wait_q + 8'd1) == TIMEOUT_LIM;
    assign err_o    = err_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign err_o          = 1'b0;
`endif

    // NOTE: every signal written here gets its default first; a branch that forgets one would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef MC_4PH_TIMEOUT_EN
        wait_d  = wait_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !ack_s) begin
                    data_d  = bus.in_data;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                req_d   = 1'b1;
                state_d = ST_REQ_HI;
`ifdef MC_4PH_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_REQ_LO;
`ifdef MC_4PH_TIMEOUT_EN
                    wait_d  = '0;
                end else if (wait_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wait_d  = wait_q + 8'd1;
`endif
                end
            end
            ST_REQ_LO: begin
                if (!ack_s) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_IDLE;
`ifdef MC_4PH_TIMEOUT_EN
                end else if (wait_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    wait_d  = wait_q + 8'd1;
`endif
                end
            end
            ST_ERR: begin
`ifdef MC_4PH_TIMEOUT_EN
                if (clr_err) begin
                    err_d = 1'b0;
                    if (!ack_s) begin
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef MC_4PH_TIMEOUT_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef MC_4PH_TIMEOUT_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    // Ready is a pure decode of registered state, forced low while reset is asserted.
    assign bus.in_ready = rst_n & (state_q == ST_IDLE) & ~ack_s;
    assign bus.req_o    = req_q;
    assign bus.data_o   = data_q;
    assign xfer_cnt     = cnt_q;

endmodule

// File: tb/tb_mc_4ph_sender.sv
// Scoreboard bench for mc_4ph_sender: accepted words are queued, and a monitor checks
// each 4-phase request against the queue; directed sequences cover reset and corner cases.
module tb_mc_4ph_sender;

    localparam int DATA_W         = 4;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 10;

    logic       clk;
    logic       rst_n;
    logic       clr_err;
    logic [7:0] xfer_cnt;
    logic       err_o;

    mc_4ph_sender_if #(.DATA_W(DATA_W)) bus ();

    mc_4ph_sender #(
        .DATA_W        (DATA_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .xfer_cnt(xfer_cnt),
        .err_o   (err_o),
        .clr_err (clr_err)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [7:0]        cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         pushed   = 0;
    logic [7:0] exp_cnt  = '0;

    // Pipeline model: ack follows req after ack_delay clock edges, or is forced.
    logic ack_force_en  = 1'b0;
    logic ack_force_val = 1'b0;
    logic ack_lag       = 1'b0;
    int   ack_delay     = 0;

    assign bus.ack_i = ack_force_en ? ack_force_val : ack_lag;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(bus.req_o);
            repeat (ack_delay) @(posedge clk);
            ack_lag = bus.req_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer a word for one clock; an offer seen with ready high is an acceptance.
    task automatic step(input logic v, input logic [DATA_W-1:0] d);
        exp_t e;
        bus.in_valid = v;
        bus.in_data  = d;
        if (v && bus.in_ready && rst_n) begin
            e.data = d;
            e.cnt  = exp_cnt;
            sb_q.push_back(e);
            exp_cnt++;
            pushed++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        clr_err      = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        check("rst_req", bus.req_o, 1'b0);
        check("rst_data", bus.data_o, '0);
        check("rst_xfer_cnt", xfer_cnt, 8'd0);
        check("rst_err", err_o, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        #1 rst_n = 1'b1;
        #1 check("in_ready_after_release", bus.in_ready, 1'b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || bus.req_o || xfer_cnt !== exp_cnt) && n < 500) begin
            step(1'b0, '0);
            n++;
        end
        check({name, "_drain_in_time"}, 32'(n < 500), 1);
        check({name, "_xfer_cnt"}, xfer_cnt, exp_cnt);
    endtask

    // Monitor: each rising req must present the next accepted word and the count so far.
    initial begin
        logic prev_req;
        exp_t cur;
        bit   cur_valid;
        prev_req  = 1'b0;
        cur_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req  = 1'b0;
                cur_valid = 1'b0;
            end else begin
                if (bus.req_o && !prev_req) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL req_without_word: req_o rose with data 0x%0h, required no request", bus.data_o);
                    end else begin
                        cur       = sb_q.pop_front();
                        cur_valid = 1'b1;
                        check("data_at_req", bus.data_o, cur.data);
                        check("cnt_at_req", xfer_cnt, cur.cnt);
                    end
                end else if (bus.req_o && cur_valid) begin
                    check("data_stable", bus.data_o, cur.data);
                end
                prev_req = bus.req_o;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        clr_err      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Zero-delay ack, in_valid held high: exact 8-cycle handshake and 8-cycle spacing.
        do_reset();
        step(1'b1, 4'hA);
        check("t1_data_edge1", bus.data_o, 4'hA);
        check("t1_req_edge1", bus.req_o, 1'b0);
        check("t1_ready_setup", bus.in_ready, 1'b0);
        step(1'b1, 4'hB);
        check("t1_req_edge2", bus.req_o, 1'b1);
        repeat (5) step(1'b1, 4'hB);
        check("t1_req_edge7", bus.req_o, 1'b0);
        check("t1_cnt_edge7", xfer_cnt, 8'd0);
        check("t1_ready_edge7", bus.in_ready, 1'b0);
        step(1'b1, 4'hB);
        check("t1_cnt_edge8", xfer_cnt, 8'd1);
        check("t1_ready_edge8", bus.in_ready, 1'b1);
        check("t1_data_held_edge8", bus.data_o, 4'hA);
        step(1'b1, 4'hB);
        check("t1_data_edge9", bus.data_o, 4'hB);
        drain("t1");

        // Ack high across reset release: no acceptance until two edges after it falls.
        ack_force_en  = 1'b1;
        ack_force_val = 1'b1;
        do_reset();
        repeat (3) step(1'b0, '0);
        check("t2_ready_ack_high", bus.in_ready, 1'b0);
        step(1'b1, 4'h5);
        check("t2_no_capture", bus.data_o, 4'h0);
        ack_force_val = 1'b0;
        step(1'b1, 4'h5);
        check("t2_ready_1_after_fall", bus.in_ready, 1'b0);
        check("t2_no_capture_1", bus.data_o, 4'h0);
        step(1'b1, 4'h5);
        check("t2_ready_2_after_fall", bus.in_ready, 1'b1);
        check("t2_no_capture_2", bus.data_o, 4'h0);
        ack_force_en = 1'b0;
        step(1'b1, 4'h5);
        check("t2_capture", bus.data_o, 4'h5);
        drain("t2");

        // Random traffic and ack latency, over 256 transfers so the counter wraps.
        begin
            int start = pushed;
            int cyc   = 0;
            while (pushed < start + 300 && cyc < 20000) begin
                ack_delay = $urandom_range(0, 3);
                step($urandom_range(0, 3) != 0, DATA_W'($urandom));
                cyc++;
            end
            check("t3_accepted_300", 32'(pushed - start >= 300), 1);
        end
        drain("t3");
        ack_delay = 0;

        // Asynchronous reset in the middle of REQ_HI abandons the transfer.
        ack_force_en  = 1'b1;
        ack_force_val = 1'b0;
        step(1'b1, 4'h7);
        step(1'b0, '0);
        step(1'b0, '0);
        check("t4_req_hi", bus.req_o, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        #1;
        check("t4_req_async", bus.req_o, 1'b0);
        check("t4_cnt_async", xfer_cnt, 8'd0);
        check("t4_ready_in_rst", bus.in_ready, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check("t4_ready_after", bus.in_ready, 1'b1);
        ack_force_en = 1'b0;
        repeat (4) step(1'b0, '0);
        check("t4_req_idle", bus.req_o, 1'b0);
        check("t4_cnt_idle", xfer_cnt, 8'd0);

        // Ack stuck low: timeout to ERR when enabled, otherwise an indefinite wait.
        ack_force_en  = 1'b1;
        ack_force_val = 1'b0;
        do_reset();
        step(1'b1, 4'h3);
        step(1'b0, '0);
        check("t5_req_entry", bus.req_o, 1'b1);
`ifdef MC_4PH_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES - 1) step(1'b0, '0);
        check("t5_err_before", err_o, 1'b0);
        check("t5_req_before", bus.req_o, 1'b1);
        step(1'b0, '0);
        check("t5_err_at_limit", err_o, 1'b1);
        check("t5_req_at_limit", bus.req_o, 1'b0);
        repeat (3) step(1'b1, 4'h9);
        check("t5_err_sticky", err_o, 1'b1);
        check("t5_ready_err", bus.in_ready, 1'b0);
        clr_err = 1'b1;
        step(1'b0, '0);
        clr_err = 1'b0;
        check("t5_err_cleared", err_o, 1'b0);
        check("t5_ready_cleared", bus.in_ready, 1'b1);
        check("t5_cnt_unchanged", xfer_cnt, 8'd0);
`else
        repeat (20) step(1'b0, '0);
        clr_err = 1'b1;
        step(1'b0, '0);
        clr_err = 1'b0;
        repeat (20) step(1'b0, '0);
        check("t5_req_waiting", bus.req_o, 1'b1);
        check("t5_err_tied", err_o, 1'b0);
        check("t5_ready_waiting", bus.in_ready, 1'b0);
        check("t5_cnt_waiting", xfer_cnt, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_4ph_sender.md
MC_4PH_SENDER -- requirements
Module: mc_4ph_sender

Interface
REQ-001 Parameter DATA_W, default 4, bundled-data payload width.
REQ-002 Parameter SYNC_STAGES, default 2, ack synchronizer depth (legal 2..3).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, ack wait limit in clk cycles (legal 1..255).
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  word offered by clocked producer.
REQ-007 in_data  input  DATA_W  offered word.
REQ-008 in_ready  output  1  sender accepts in_data this cycle.
REQ-009 req_o  output  1  4-phase request into the Muller C-element pipeline.
REQ-010 data_o  output  DATA_W  bundled data, stable while req_o=1.
REQ-011 ack_i  input  1  asynchronous 4-phase acknowledge from the C-element pipeline.
REQ-012 xfer_cnt  output  8  completed-handshake count.
REQ-013 err_o  output  1  sticky timeout flag.
REQ-014 clr_err  input  1  clears err_o, single-cycle pulse.

Function
REQ-015 ack_i SHALL pass through a SYNC_STAGES flop chain; only the last stage (ack_s) SHALL be used.
REQ-016 FSM states: IDLE, SETUP, REQ_HI, REQ_LO, ERR; all outputs registered.
REQ-017 IDLE: in_ready=1 iff ack_s=0; accept on in_valid&in_ready -> data_o<=in_data, next SETUP.
REQ-018 SETUP: one cycle, req_o stays 0 (bundled-data setup margin); next REQ_HI with req_o<=1.
REQ-019 REQ_HI: req_o=1; ack_s=1 -> req_o<=0, next REQ_LO.
REQ-020 REQ_LO: req_o=0; ack_s=0 -> xfer_cnt<=xfer_cnt+1 (mod 256, 255->0 wraps), next IDLE.
REQ-021 data_o SHALL change only on acceptance in IDLE; held through SETUP, REQ_HI, REQ_LO, ERR.
REQ-022 in_ready SHALL be 0 in every state except IDLE.
REQ-023 ack_s=1 while IDLE (protocol violation/residue): in_ready=0, no acceptance until ack_s=0.
REQ-024 Minimum accept-to-accept spacing: 4 + 2*SYNC_STAGES cycles with zero-delay ack.
REQ-025 Simultaneous in_valid and REQ_LO completion: word not accepted until the cycle after return to IDLE.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, req_o=0, data_o=0, xfer_cnt=0, err_o=0, sync chain 0, wait counter 0.
REQ-027 in_ready SHALL read 0 while rst_n=0 and 1 on the first cycle after release (ack_s=0).
REQ-028 Reset mid-handshake SHALL abandon the transfer without incrementing xfer_cnt; no recovery sequencing.

Configuration
REQ-029 Macro MC_4PH_TIMEOUT_EN defined: 8-bit wait counter clears on entering REQ_HI/REQ_LO and increments each cycle there; reaching TIMEOUT_CYCLES -> req_o<=0, err_o<=1, next ERR.
REQ-030 ERR: in_ready=0; exit to IDLE when clr_err=1 and ack_s=0; clr_err clears err_o same edge; xfer_cnt unchanged.
REQ-031 Macro undefined: no counter, ERR unreachable, err_o tied 0, clr_err ignored, FSM waits indefinitely.

Verification
REQ-032 Reset release, in_valid=1, in_data=4'hA, ack_i mirrors req_o zero delay -> data_o=A at edge 1, req_o=1 at edge 2, returns IDLE, xfer_cnt=1, total 8 cycles.
REQ-033 ack_i held 1 at reset release -> in_ready=0 until 2 cycles after ack_i falls; in_data not captured meanwhile.
REQ-034 256 back-to-back transfers -> xfer_cnt wraps 255->0; data_o matches each accepted word while req_o=1.
REQ-035 MC_4PH_TIMEOUT_EN, TIMEOUT_CYCLES=10, ack_i stuck 0 -> err_o=1 and req_o=0 10 cycles after REQ_HI entry; clr_err with ack_i=0 -> IDLE, err_o=0.
REQ-036 rst_n pulsed low asynchronously mid-REQ_HI -> req_o=0 before next clk edge, xfer_cnt=0, state IDLE.
